addr_burst_scheduler: RTL and testbench
=======================================

ADDR_BURST_SCHEDULER -- requirements
Module: addr_burst_scheduler

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters.
REQ-002 SHALL have parameter BITWIDTH, default 5: address width.
REQ-003 SHALL have parameter MAX_ADDRESS, default 20: address count; addresses run 0..MAX_ADDRESS-1.
REQ-004 SHALL have parameter BURST_LEN, default 4: addresses issued per grant (1..MAX_ADDRESS).
REQ-005 SHALL have port clock, input, 1: the single clock; all logic on rising edge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port req, input, NUM_REQ: level request per requester.
REQ-008 SHALL have port addr_ready, input, 1: consumer accepts current address.
REQ-009 SHALL have port grant, output, NUM_REQ: one-hot owner of current burst.
REQ-010 SHALL have port address, output, BITWIDTH: current address.
REQ-011 SHALL have port addr_valid, output, 1: address is valid this cycle.
REQ-012 SHALL have port beat_last, output, 1: current address is final beat of burst.
REQ-013 SHALL have port done, output, NUM_REQ: one-cycle pulse to owner on burst completion.
REQ-014 SHALL have port busy, output, 1: state is not IDLE.

Function
REQ-015 SHALL implement FSM IDLE -> BURST -> DONE -> IDLE; all outputs registered.
REQ-016 IDLE: if any req high, SHALL pick winner round-robin, lowest index after last winner first; grant and addr_valid assert the next cycle (1-cycle grant latency).
REQ-017 BURST: SHALL hold addr_valid=1, grant one-hot, address=pointer; beat advances only on addr_valid && addr_ready.
REQ-018 On beat accept SHALL increment pointer; pointer==MAX_ADDRESS-1 wraps to 0 (no intermediate out-of-range value).
REQ-019 beat_last SHALL be 1 while beat count == BURST_LEN-1 in BURST.
REQ-020 On accepting last beat SHALL enter DONE: addr_valid=0, grant=0, done[owner]=1 for exactly one cycle.
REQ-021 DONE SHALL return to IDLE unconditionally; minimum one idle cycle between bursts.
REQ-022 addr_ready low SHALL hold address, beat count, grant unchanged indefinitely.
REQ-023 req deassertion during BURST SHALL be ignored; burst runs to completion.
REQ-024 Round-robin pointer SHALL update to the winner index when the burst is granted.
REQ-025 Requests arriving during BURST/DONE SHALL be evaluated only in IDLE.

Reset
REQ-026 On reset high at a clock edge, SHALL next cycle drive grant=0, address=0, addr_valid=0, beat_last=0, done=0, busy=0, state IDLE.
REQ-027 Reset SHALL clear address pointer(s) and beat count to 0 and set round-robin so requester 0 wins first; reset mid-burst aborts with no done pulse.

Configuration
REQ-028 Macro ADDR_SCHED_PRIV_PTR_EN defined: SHALL keep one address pointer per requester; burst starts at owner's own pointer.
REQ-029 Macro undefined: SHALL use a single shared pointer; each burst continues where the previous one ended.

Structure
REQ-030 Package addr_sched_pkg SHALL hold FSM state typedef (IDLE, BURST, DONE) and default parameter constants.
REQ-031 Round-robin selection SHALL be sub-module rr_arbiter (inputs req, last winner; output one-hot winner, combinational).

Verification (NUM_REQ=4, MAX_ADDRESS=20, BURST_LEN=4)
REQ-032 req=0001, ready=1 -> grant=0001 one cycle later; addresses 0,1,2,3; beat_last on 3; done=0001 next cycle; busy=0 after.
REQ-033 Shared pointer at 18, req=0010 -> addresses 18,19,0,1.
REQ-034 req=1111 held -> grant order 0001,0010,0100,1000,0001.
REQ-035 ready low on beat 2 for 3 cycles -> address holds at 2, grant unchanged; burst resumes 2,3.
REQ-036 reset on beat 1 -> next cycle all outputs 0, no done; next req0 burst starts at 0.
REQ-037 ADDR_SCHED_PRIV_PTR_EN: req0 burst (0..3) then req1 -> req1 addresses 0..3; next req0 -> 4..7.

Source files
------------

// File: rtl/addr_sched_pkg.sv
// Shared types and default sizing for the address burst scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package addr_sched_pkg;

    // Scheduler FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Default sizing
    localparam int DEF_NUM_REQ     = 4;
    localparam int DEF_BITWIDTH    = 5;
    localparam int DEF_MAX_ADDRESS = 20;
    localparam int DEF_BURST_LEN   = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: lowest requester index after the last winner wins.
// Latency: combinational.
// Backpressure: none; the caller decides when the pick is consumed.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDXW    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDXW-1:0]    last,
    output logic [NUM_REQ-1:0] grant
);

    // Scan from the slot after the last winner, wrapping around once
    always_comb begin
        int  idx;
        logic found;
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = (int'(last) + i) % NUM_REQ;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/addr_burst_scheduler.sv
// Grants one requester at a time a burst of BURST_LEN consecutive addresses (wrapping at MAX_ADDRESS);
// optional macro ADDR_SCHED_PRIV_PTR_EN gives each requester its own address pointer.
// Latency: grant/addr_valid one cycle after req seen in IDLE; beats advance on addr_valid && addr_ready, stall indefinitely otherwise.
module addr_burst_scheduler
    import addr_sched_pkg::*;
#(
    parameter int NUM_REQ     = DEF_NUM_REQ,
    parameter int BITWIDTH    = DEF_BITWIDTH,
    parameter int MAX_ADDRESS = DEF_MAX_ADDRESS,
    parameter int BURST_LEN   = DEF_BURST_LEN
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_REQ-1:0]  req,
    input  logic                addr_ready,
    output logic [NUM_REQ-1:0]  grant,
    output logic [BITWIDTH-1:0] address,
    output logic                addr_valid,
    output logic                beat_last,
    output logic [NUM_REQ-1:0]  done,
    output logic                busy
);

    localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNTW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    localparam logic [CNTW-1:0]     LAST_BEAT = CNTW'(BURST_LEN - 1);
    localparam logic [BITWIDTH-1:0] ADDR_LAST = BITWIDTH'(MAX_ADDRESS - 1);

    state_t             state_q;
    state_t             state_d;
    logic [CNTW-1:0]    beat_cnt;
    logic [IDXW-1:0]    last_win;
    logic [NUM_REQ-1:0] win_oh;
    logic [IDXW-1:0]    win_idx;
    logic [BITWIDTH-1:0] addr_nxt;
    logic               beat_acc;

`ifdef ADDR_SCHED_PRIV_PTR_EN
    logic [BITWIDTH-1:0] ptr_q [NUM_REQ];
    logic [IDXW-1:0]     owner_q;
`else
    logic [BITWIDTH-1:0] ptr_q;
`endif

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDXW    (IDXW)
    ) u_arb (
        .req   (req),
        .last  (last_win),
        .grant (win_oh)
    );

    // One-hot winner to index for pointer bookkeeping
    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_oh[i]) win_idx = IDXW'(i);
        end
    end

    // Beat handshake and wrapped successor address
    always_comb begin
        beat_acc = addr_valid && addr_ready;
        addr_nxt = (address == ADDR_LAST) ? '0 : address + 1'b1;
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state: requests only matter in IDLE; DONE always falls back to IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|req) state_d = BURST;
            BURST:   if (beat_acc && beat_cnt == LAST_BEAT) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Registered outputs, beat counter, address pointers and round-robin history
    always_ff @(posedge clock) begin
        if (reset) begin
            grant      <= '0;
            address    <= '0;
            addr_valid <= 1'b0;
            beat_last  <= 1'b0;
            done       <= '0;
            busy       <= 1'b0;
            beat_cnt   <= '0;
            // Pretend the top index won last so requester 0 is first in line
            last_win   <= IDXW'(NUM_REQ - 1);
`ifdef ADDR_SCHED_PRIV_PTR_EN
            owner_q    <= '0;
            for (int i = 0; i < NUM_REQ; i++) ptr_q[i] <= '0;
`else
            ptr_q      <= '0;
`endif
        end else begin
            done <= '0;
            case (state_q)
                IDLE: begin
                    if (|req) begin
                        grant      <= win_oh;
                        last_win   <= win_idx;
                        addr_valid <= 1'b1;
                        busy       <= 1'b1;
                        beat_cnt   <= '0;
                        beat_last  <= (LAST_BEAT == '0);
`ifdef ADDR_SCHED_PRIV_PTR_EN
                        owner_q    <= win_idx;
                        address    <= ptr_q[win_idx];
`else
                        address    <= ptr_q;
`endif
                    end
                end
                BURST: begin
                    if (beat_acc) begin
`ifdef ADDR_SCHED_PRIV_PTR_EN
                        ptr_q[owner_q] <= addr_nxt;
`else
                        ptr_q          <= addr_nxt;
`endif
                        if (beat_cnt == LAST_BEAT) begin
                            addr_valid <= 1'b0;
                            beat_last  <= 1'b0;
                            grant      <= '0;
                            done       <= grant;
                        end else begin
                            address    <= addr_nxt;
                            beat_cnt   <= beat_cnt + 1'b1;
                            beat_last  <= ((beat_cnt + 1'b1) == LAST_BEAT);
                        end
                    end
                end
                DONE: begin
                    busy <= 1'b0;
                end
                default: begin
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_addr_burst_scheduler.sv
// Directed bench for addr_burst_scheduler (NUM_REQ=4, MAX_ADDRESS=20, BURST_LEN=4) plus a
// BURST_LEN=6 instance used to walk the shared pointer up to the wrap boundary.
// Inputs change 1 time unit after a rising edge; outputs are checked at that same point.
module tb_addr_burst_scheduler;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] req = '0;
    logic       addr_ready = 1'b0;
    logic [3:0] grant;
    logic [4:0] address;
    logic       addr_valid;
    logic       beat_last;
    logic [3:0] done;
    logic       busy;

    logic [3:0] req_w = '0;
    logic       ready_w = 1'b0;
    logic [3:0] grant_w;
    logic [4:0] address_w;
    logic       valid_w;
    logic       last_w;
    logic [3:0] done_w;
    logic       busy_w;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clock = ~clock;

    addr_burst_scheduler #(
        .NUM_REQ(4), .BITWIDTH(5), .MAX_ADDRESS(20), .BURST_LEN(4)
    ) dut (
        .clock(clock), .reset(reset), .req(req), .addr_ready(addr_ready),
        .grant(grant), .address(address), .addr_valid(addr_valid),
        .beat_last(beat_last), .done(done), .busy(busy)
    );

    addr_burst_scheduler #(
        .NUM_REQ(4), .BITWIDTH(5), .MAX_ADDRESS(20), .BURST_LEN(6)
    ) dut_w (
        .clock(clock), .reset(reset), .req(req_w), .addr_ready(ready_w),
        .grant(grant_w), .address(address_w), .addr_valid(valid_w),
        .beat_last(last_w), .done(done_w), .busy(busy_w)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1; req = '0; addr_ready = 1'b0; req_w = '0; ready_w = 1'b0;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; req = 4'b1111; addr_ready = 1'b1;
        step();
        tests_run++; if (grant !== 4'b0) begin tests_failed++; $display("FAIL reset_grant got %b want 0000", grant); end
        tests_run++; if (address !== 5'd0) begin tests_failed++; $display("FAIL reset_address got %0d want 0", address); end
        tests_run++; if (addr_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got %b want 0", addr_valid); end
        tests_run++; if (beat_last !== 1'b0) begin tests_failed++; $display("FAIL reset_beat_last got %b want 0", beat_last); end
        tests_run++; if (done !== 4'b0) begin tests_failed++; $display("FAIL reset_done got %b want 0000", done); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b want 0", busy); end
        reset = 1'b0; req = '0; addr_ready = 1'b0;
    endtask

    task automatic test_single_burst();
        apply_reset();
        req = 4'b0001; addr_ready = 1'b1;
        step();
        req = '0;
        tests_run++; if (grant !== 4'b0001) begin tests_failed++; $display("FAIL single_grant got %b want 0001", grant); end
        tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL single_busy got %b want 1", busy); end
        for (int b = 0; b < 4; b++) begin
            tests_run++;
            if (address !== 5'(b) || addr_valid !== 1'b1 || beat_last !== (b == 3)) begin
                tests_failed++;
                $display("FAIL single_beat%0d got addr=%0d vld=%b last=%b want addr=%0d vld=1 last=%b",
                         b, address, addr_valid, beat_last, b, (b == 3));
            end
            step();
        end
        tests_run++;
        if (done !== 4'b0001 || addr_valid !== 1'b0 || grant !== 4'b0) begin
            tests_failed++;
            $display("FAIL single_done got done=%b vld=%b grant=%b want done=0001 vld=0 grant=0000", done, addr_valid, grant);
        end
        step();
        tests_run++;
        if (busy !== 1'b0 || done !== 4'b0) begin
            tests_failed++;
            $display("FAIL single_idle got busy=%b done=%b want busy=0 done=0000", busy, done);
        end
    endtask

    task automatic test_ptr_mode();
        logic [3:0] who [3];
        logic [4:0] start [3];
        who[0] = 4'b0001; who[1] = 4'b0010; who[2] = 4'b0001;
`ifdef ADDR_SCHED_PRIV_PTR_EN
        start[0] = 5'd0; start[1] = 5'd0; start[2] = 5'd4;
`else
        start[0] = 5'd0; start[1] = 5'd4; start[2] = 5'd8;
`endif
        apply_reset();
        addr_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            req = who[k];
            step();
            req = '0;
            tests_run++;
            if (grant !== who[k]) begin
                tests_failed++; $display("FAIL ptr_grant%0d got %b want %b", k, grant, who[k]);
            end
            for (int b = 0; b < 4; b++) begin
                tests_run++;
                if (address !== 5'(start[k] + 5'(b))) begin
                    tests_failed++;
                    $display("FAIL ptr_burst%0d_beat%0d got %0d want %0d", k, b, address, start[k] + 5'(b));
                end
                step();
            end
            tests_run++;
            if (done !== who[k]) begin
                tests_failed++; $display("FAIL ptr_done%0d got %b want %b", k, done, who[k]);
            end
            step();
        end
    endtask

    task automatic test_wrap();
        logic [4:0] exp_addr [4];
        apply_reset();
        req_w = 4'b0010; ready_w = 1'b1;
        step();
        // Bursts of 6 start at 0, 6, 12, then 18; each grant is 8 cycles after the previous one
        for (int k = 0; k < 3; k++) begin
            tests_run++;
            if (address_w !== 5'(6 * k) || grant_w !== 4'b0010) begin
                tests_failed++;
                $display("FAIL wrap_start%0d got addr=%0d grant=%b want addr=%0d grant=0010", k, address_w, grant_w, 6 * k);
            end
            for (int c = 0; c < 8; c++) step();
        end
        req_w = '0;
        exp_addr[0] = 5'd18; exp_addr[1] = 5'd19; exp_addr[2] = 5'd0; exp_addr[3] = 5'd1;
        for (int b = 0; b < 4; b++) begin
            tests_run++;
            if (address_w !== exp_addr[b] || valid_w !== 1'b1) begin
                tests_failed++;
                $display("FAIL wrap_beat%0d got addr=%0d vld=%b want addr=%0d vld=1", b, address_w, valid_w, exp_addr[b]);
            end
            step();
        end
        ready_w = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [3:0] order [5];
        order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100; order[3] = 4'b1000; order[4] = 4'b0001;
        apply_reset();
        req = 4'b1111; addr_ready = 1'b1;
        step();
        for (int k = 0; k < 5; k++) begin
            tests_run++;
            if (grant !== order[k]) begin
                tests_failed++; $display("FAIL rr_grant%0d got %b want %b", k, grant, order[k]);
            end
            for (int c = 0; c < 4; c++) step();
            tests_run++;
            if (done !== order[k] || busy !== 1'b1) begin
                tests_failed++; $display("FAIL rr_done%0d got done=%b busy=%b want done=%b busy=1", k, done, busy, order[k]);
            end
            step();
            tests_run++;
            if (addr_valid !== 1'b0 || grant !== 4'b0) begin
                tests_failed++; $display("FAIL rr_idle_gap%0d got vld=%b grant=%b want vld=0 grant=0000", k, addr_valid, grant);
            end
            step();
        end
        req = '0;
    endtask

    task automatic test_stall();
        apply_reset();
        req = 4'b0001; addr_ready = 1'b1;
        step();
        req = '0;
        step();
        step();
        addr_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            tests_run++;
            if (address !== 5'd2 || grant !== 4'b0001 || addr_valid !== 1'b1 || beat_last !== 1'b0) begin
                tests_failed++;
                $display("FAIL stall_hold%0d got addr=%0d grant=%b vld=%b last=%b want addr=2 grant=0001 vld=1 last=0",
                         c, address, grant, addr_valid, beat_last);
            end
        end
        addr_ready = 1'b1;
        step();
        tests_run++;
        if (address !== 5'd3 || beat_last !== 1'b1) begin
            tests_failed++; $display("FAIL stall_resume got addr=%0d last=%b want addr=3 last=1", address, beat_last);
        end
        step();
        tests_run++;
        if (done !== 4'b0001) begin
            tests_failed++; $display("FAIL stall_done got %b want 0001", done);
        end
        step();
    endtask

    task automatic test_reset_mid_burst();
        apply_reset();
        req = 4'b0001; addr_ready = 1'b1;
        step();
        req = '0;
        step();
        tests_run++;
        if (address !== 5'd1) begin
            tests_failed++; $display("FAIL midrst_pre got addr=%0d want 1", address);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        tests_run++;
        if (grant !== 4'b0 || address !== 5'd0 || addr_valid !== 1'b0 || beat_last !== 1'b0 || done !== 4'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_outputs got grant=%b addr=%0d vld=%b last=%b done=%b busy=%b want all zero",
                     grant, address, addr_valid, beat_last, done, busy);
        end
        step();
        tests_run++;
        if (done !== 4'b0) begin
            tests_failed++; $display("FAIL midrst_no_done got %b want 0000", done);
        end
        req = 4'b0001;
        step();
        req = '0;
        tests_run++;
        if (address !== 5'd0 || grant !== 4'b0001) begin
            tests_failed++; $display("FAIL midrst_restart got addr=%0d grant=%b want addr=0 grant=0001", address, grant);
        end
        for (int c = 0; c < 6; c++) step();
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_ptr_mode();
        test_wrap();
        test_back_to_back();
        test_stall();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
